mext_issue_ctrl: RTL
====================

Name: mext_issue_ctrl

Overview:
Execute-stage controller for RV32M multiply instructions (MUL/MULH/MULHSU/MULHU). It sits between the ID/EX pipeline register and the iterative multiplier. It decodes funct3 to the multiplier opcode, issues a one-cycle start pulse, and stalls the front of the pipeline while the multiplier iterates. It then presents the 32-bit result to the EX/MEM register, handles flushes, and reuses the previous result when operands and opcode repeat.

Parameters:
MAX_LAT, 40, WAIT-state cycle limit before timeout (multiplier nominal latency 33-34 cycles)
EN_REUSE, 1, 1 = enable last-result reuse; 0 = always launch

Ports:
clk  in  1  clock
rst  in  1  reset
valid_e  in  1  valid instruction in EX
is_mext_e  in  1  instruction is OP with funct7=0000001
funct3_e  in  3  instruction funct3
rs1_e  in  32  forwarded rs1 value
rs2_e  in  32  forwarded rs2 value
rd_e  in  5  destination register
flush_e  in  1  kill instruction in EX (branch/trap)
stall_m  in  1  downstream stall; EX/MEM cannot accept
mul_done  in  1  multiplier completion pulse; mul_result valid this cycle
mul_result  in  32  multiplier result
mul_start  out  1  one-cycle start pulse to multiplier
mul_opcode  out  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
mul_op1  out  32  latched rs1
mul_op2  out  32  latched rs2
stall_o  out  1  freeze PC, IF/ID and ID/EX
res_valid  out  1  result available for EX/MEM this cycle
res_data  out  32  result
res_rd  out  5  destination of result
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All outputs are 0. State is IDLE. Reuse entry is invalid. Counter is 0.
- mul request: req = valid_e & is_mext_e & ~funct3_e[2] & ~flush_e. The funct3[2]=1 (div/rem) case is ignored here: no stall and no start.
- Opcode mapping: mul_opcode = funct3_e[1:0].
- States: IDLE, LAUNCH, WAIT, DONE, DRAIN.
- IDLE:
  - On req: stall_o=1 (combinational).
  - Latch op1, op2, opcode and rd.
  - If EN_REUSE, the entry is valid, and op1/op2/opcode all match: load res_data from the entry and go to DONE. Total latency is 1 cycle to DONE.
  - Otherwise go to LAUNCH.
- LAUNCH:
  - mul_start=1 for exactly this cycle; stall_o=1; go to WAIT. Counter is cleared.
  - If flush_e: no start pulse; go to IDLE.
- WAIT:
  - stall_o=1; counter increments every cycle.
  - On mul_done: capture mul_result; write the reuse entry {op1, op2, opcode, result, valid=1}; go to DONE.
  - On flush_e without mul_done: go to DRAIN.
  - On flush_e together with mul_done: the reuse entry is written; go to IDLE.
  - If counter reaches MAX_LAT with no done: set err_timeout (sticky until rst), res_data=0, go to DONE.
- DONE:
  - res_valid=1, res_data and res_rd driven.
  - stall_o = stall_m.
  - If stall_m=0: go to IDLE; the instruction advances this edge.
  - If stall_m=1: hold, with outputs stable.
  - If flush_e: res_valid=0, stall_o=0, go to IDLE.
- DRAIN:
  - The multiplier cannot abort. Wait for mul_done, discard the result (the reuse entry is still written), then go to IDLE.
  - stall_o=1 if a new req is present.
  - Timeout rules as in WAIT. Timeout exits to IDLE; no result is delivered.
- mul_op1/mul_op2/mul_opcode are held stable from LAUNCH through the end of WAIT/DRAIN.
- mul_done outside WAIT/DRAIN is ignored.
- Back-to-back requests: a new instruction enters EX the cycle after DONE exits. A request is evaluated only in IDLE.
- Reset mid-operation: immediate return to IDLE, no pulse. The multiplier is reset by the same rst.

Decomposition:
- Shared package mext_pkg:
  - mul_op_t enum (MUL, MULH, MULHSU, MULHU = 2'b00..2'b11)
  - mext_state_t enum
  - localparam OPCODE_M_EXT = 7'b0110011
  - localparam FUNCT7_MEXT = 7'b0000001
- Sub-module: mext_reuse_entry (single-entry tag/result register with compare).

Test Plan:
- MUL rs1=7, rs2=6, mul_done 33 cycles after start with result 42 -> start pulses once in LAUNCH; stall_o high until DONE; res_valid=1, res_data=42, res_rd=rd_e; IDLE next cycle.
- Repeat MULHU with identical ops 0xFFFFFFFF×0xFFFFFFFF after a completed run (result 0xFFFFFFFE) -> no mul_start; res_valid with 0xFFFFFFFE one cycle after request.
- flush_e in WAIT cycle 10 -> DRAIN; res_valid never asserts; mul_done later consumed; the next MUL (3×5) issues normally and yields 15.
- stall_m held 3 cycles in DONE -> res_valid and res_data stable for 4 cycles; stall_o mirrors stall_m; single advance.
- No mul_done after start (MAX_LAT=40) -> err_timeout=1 after 40 WAIT cycles; res_data=0; err_timeout stays 1.
- DIVU (funct3=101) in EX -> stall_o=0, mul_start=0; rst asserted mid-WAIT -> all outputs 0 asynchronously, reuse invalidated.

Source files
------------

// File: rtl/mext_pkg.sv
// Shared types and constants for the RV32M multiply issue controller.
package mext_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_DRAIN  = 3'd4
    } mext_state_t;

    localparam logic [6:0] OPCODE_M_EXT = 7'b0110011;
    localparam logic [6:0] FUNCT7_MEXT  = 7'b0000001;

    // Identity of a multiply: what must match for a result to be reused.
    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        mul_op_t     opc;
    } mext_tag_t;

endpackage

// File: rtl/mext_reuse_entry.sv
// Single-entry memo of the last completed multiply: tag, result and valid,
// with a combinational compare against the instruction currently in EX.
module mext_reuse_entry
    import mext_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  mext_tag_t   wr_tag,
    input  logic [31:0] wr_res,
    input  mext_tag_t   cmp_tag,
    output logic        hit,
    output logic [31:0] hit_res
);

    logic        valid_q, valid_d;
    mext_tag_t   tag_q, tag_d;
    logic [31:0] res_q, res_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        res_d   = res_q;
        if (wr_en) begin
            valid_d = 1'b1;
            tag_d   = wr_tag;
            res_d   = wr_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            res_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
        end
    end

    assign hit     = valid_q && (tag_q == cmp_tag);
    assign hit_res = res_q;

endmodule

// File: rtl/mext_issue_ctrl.sv
// EX-stage sequencer for MUL/MULH/MULHSU/MULHU: launches the iterative
// multiplier, stalls the front end, delivers the result, handles flush/timeout.
module mext_issue_ctrl
    import mext_pkg::*;
#(
    parameter int MAX_LAT  = 40,
    parameter bit EN_REUSE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_e,
    input  logic        is_mext_e,
    input  logic [2:0]  funct3_e,
    input  logic [31:0] rs1_e,
    input  logic [31:0] rs2_e,
    input  logic [4:0]  rd_e,
    input  logic        flush_e,
    input  logic        stall_m,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        mul_start,
    output logic [1:0]  mul_opcode,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    output logic        stall_o,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        err_timeout
);

    localparam int CW = $clog2(MAX_LAT + 1);

    mext_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    mul_op_t       opc_q, opc_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   res_q, res_d;
    logic          err_q, err_d;

    logic          req, hit, reuse_hit, ent_wr, timeout;
    logic [31:0]   hit_res;
    mext_tag_t     cmp_tag, wr_tag;

    // Div/rem share the M-extension encoding but are handled elsewhere.
    assign req       = valid_e & is_mext_e & ~funct3_e[2] & ~flush_e;
    assign cmp_tag   = '{op1: rs1_e, op2: rs2_e, opc: mul_op_t'(funct3_e[1:0])};
    assign wr_tag    = '{op1: op1_q, op2: op2_q, opc: opc_q};
    assign reuse_hit = EN_REUSE && hit;
    assign timeout   = (cnt_q == CW'(MAX_LAT - 1));

    mext_reuse_entry u_reuse (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ent_wr),
        .wr_tag  (wr_tag),
        .wr_res  (mul_result),
        .cmp_tag (cmp_tag),
        .hit     (hit),
        .hit_res (hit_res)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opc_d     = opc_q;
        rd_d      = rd_q;
        res_d     = res_q;
        err_d     = err_q;
        mul_start = 1'b0;
        stall_o   = 1'b0;
        res_valid = 1'b0;
        ent_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    stall_o = 1'b1;
                    op1_d   = rs1_e;
                    op2_d   = rs2_e;
                    opc_d   = mul_op_t'(funct3_e[1:0]);
                    rd_d    = rd_e;
                    if (reuse_hit) begin
                        res_d   = hit_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                stall_o = 1'b1;
                cnt_d   = '0;
                if (flush_e) begin
                    state_d = S_IDLE;
                end else begin
                    mul_start = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (mul_done) begin
                    ent_wr  = 1'b1;
                    res_d   = mul_result;
                    state_d = flush_e ? S_IDLE : S_DONE;
                end else if (flush_e) begin
                    state_d = S_DRAIN;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush_e) begin
                    state_d = S_IDLE;
                end else begin
                    res_valid = 1'b1;
                    stall_o   = stall_m;
                    if (!stall_m) state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Multiplier cannot abort; its result still refreshes the memo.
                stall_o = req;
                cnt_d   = cnt_q + 1'b1;
                if (mul_done) begin
                    ent_wr  = 1'b1;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            opc_q   <= MUL;
            rd_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            opc_q   <= opc_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign mul_op1     = op1_q;
    assign mul_op2     = op2_q;
    assign mul_opcode  = opc_q;
    assign res_data    = res_valid ? res_q : '0;
    assign res_rd      = res_valid ? rd_q : '0;
    assign err_timeout = err_q;

endmodule
